// File: rtl/retire_commit_unit_pkg.sv
// rtl/retire_commit_unit_pkg.sv - shared types and widths for the retire/commit stage
package retire_commit_unit_pkg;

    localparam int XLEN          = 32;
    localparam int REG_IDX_W     = 5;
    localparam int PHYS_REGS_DEF = 64;
    localparam int PHYS_TAG_W    = $clog2(PHYS_REGS_DEF);
    localparam int ROB_IDX_W     = 5;

    typedef enum logic [1:0] {
        RUN,
        RECOVER,
        HALTED
    } retire_state_e;

    typedef struct packed {
        logic                  complete;
        logic                  is_store;
        logic                  halt;
        logic                  is_branch;
        logic                  pred_taken;
        logic                  branch_taken;
        logic [XLEN-1:0]       pred_target;
        logic [XLEN-1:0]       branch_target;
        logic [REG_IDX_W-1:0]  arch_rd;
        logic [PHYS_TAG_W-1:0] phys_rd;
        logic [PHYS_TAG_W-1:0] prev_phys_rd;
    } rob_entry_t;

    function automatic logic is_mispredict(input rob_entry_t e);
        return e.is_branch &&
               ((e.pred_taken != e.branch_taken) ||
                (e.branch_taken && (e.pred_target != e.branch_target)));
    endfunction

endpackage

// File: rtl/retire_commit_unit_select.sv
// rtl/retire_commit_unit_select.sv - in-order lane qualification with prefix stop
module retire_select
    import retire_commit_unit_pkg::*;
#(
    parameter  int N              = 4,
    parameter  int STORES_PER_CYC = 1,
    localparam int CW             = $clog2(N + 1),
    localparam int SW             = $clog2(STORES_PER_CYC + 1),
    localparam int LW             = (N > 1) ? $clog2(N) : 1
) (
    input  rob_entry_t [N-1:0] entries,
    input  logic [N-1:0]       valids,
    input  logic               sq_ready,
    output logic [N-1:0]       commit,
    output logic [CW-1:0]      count,
    output logic [SW-1:0]      store_count,
    output logic               mispredict,
    output logic [LW-1:0]      flush_lane,
    output logic               halt
);

    localparam logic [SW-1:0] STORE_MAX = SW'(STORES_PER_CYC);

    always_comb begin
        logic stop;
        commit      = '0;
        count       = '0;
        store_count = '0;
        mispredict  = 1'b0;
        flush_lane  = '0;
        halt        = 1'b0;
        stop        = 1'b0;
        // lane N-1 is the oldest; the first lane that cannot commit blocks all younger ones
        for (int i = N - 1; i >= 0; i--) begin
            if (!stop) begin
                if (!valids[i] || !entries[i].complete) begin
                    stop = 1'b1;
                end else if (entries[i].is_store && (!sq_ready || store_count == STORE_MAX)) begin
                    stop = 1'b1;
                end else begin
                    commit[i] = 1'b1;
                    count     = count + CW'(1);
                    if (entries[i].is_store) begin
                        store_count = store_count + SW'(1);
                    end
                    if (is_mispredict(entries[i])) begin
                        mispredict = 1'b1;
                        flush_lane = LW'(i);
                        stop       = 1'b1;
                    end
                    if (entries[i].halt) begin
                        halt = 1'b1;
                        stop = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/retire_commit_unit.sv
// rtl/retire_commit_unit.sv - N-wide in-order commit with recovery, halt and instret
module retire_commit_unit
    import retire_commit_unit_pkg::*;
#(
    parameter  int N              = 4,
    parameter  int PHYS_REGS      = PHYS_REGS_DEF,
    parameter  int RECOVER_CYCLES = 2,
    parameter  int STORES_PER_CYC = 1,
    localparam int CW             = $clog2(N + 1),
    localparam int SW             = $clog2(STORES_PER_CYC + 1),
    localparam int LW             = (N > 1) ? $clog2(N) : 1,
    localparam int RCW            = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1
) (
    input  logic                              clock,
    input  logic                              reset,
    input  rob_entry_t [N-1:0]                headEntries,
    input  logic [N-1:0]                      headValids,
    input  logic [N-1:0][ROB_IDX_W-1:0]       headIdxs,
    input  logic                              sqCommitReady,
    output logic [CW-1:0]                     retireCount,
    output logic [SW-1:0]                     sqCommitCount,
    output logic                              robFlush,
    output logic [ROB_IDX_W-1:0]              robFlushIdx,
    output logic                              bpRecoverEn,
    output logic                              recovering,
    output logic [N-1:0]                      archWriteEnables,
    output logic [N-1:0][REG_IDX_W-1:0]       archWriteAddrs,
    output logic [N-1:0][PHYS_TAG_W-1:0]      archWritePhysRegs,
    output logic [PHYS_REGS-1:0]              freeMask,
    output logic                              halted,
    output logic [63:0]                       instret
);

    retire_state_e state, state_next;
    logic [RCW-1:0] cnt, cnt_next;

    logic [N-1:0]  sel_commit;
    logic [CW-1:0] sel_count;
    logic [SW-1:0] sel_store_count;
    logic          sel_mispredict;
    logic [LW-1:0] sel_flush_lane;
    logic          sel_halt;

    logic                            active;
    logic [N-1:0]                    commit;
    logic [N-1:0]                    en_next;
    logic [N-1:0][REG_IDX_W-1:0]     addr_next;
    logic [N-1:0][PHYS_TAG_W-1:0]    phys_next;
    logic [PHYS_REGS-1:0]            free_next;

    retire_select #(
        .N              (N),
        .STORES_PER_CYC (STORES_PER_CYC)
    ) u_select (
        .entries     (headEntries),
        .valids      (headValids),
        .sq_ready    (sqCommitReady),
        .commit      (sel_commit),
        .count       (sel_count),
        .store_count (sel_store_count),
        .mispredict  (sel_mispredict),
        .flush_lane  (sel_flush_lane),
        .halt        (sel_halt)
    );

    assign active = !reset && (state == RUN);
    assign commit = active ? sel_commit : '0;

    always_comb begin
        retireCount   = active ? sel_count : '0;
        sqCommitCount = active ? sel_store_count : '0;
        robFlush      = active && sel_mispredict;
        bpRecoverEn   = robFlush;
        robFlushIdx   = robFlush ? headIdxs[sel_flush_lane] : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            RUN: begin
                if (robFlush) begin
                    state_next = RECOVER;
                    cnt_next   = RCW'(RECOVER_CYCLES - 1);
                end else if (active && sel_halt) begin
                    state_next = HALTED;
                end
            end
            RECOVER: begin
                if (cnt == '0) begin
                    state_next = RUN;
                end else begin
                    cnt_next = cnt - RCW'(1);
                end
            end
            HALTED:  state_next = HALTED;
            default: state_next = RUN;
        endcase
    end

    assign recovering = (state == RECOVER);
    assign halted     = (state == HALTED);

    always_comb begin
        en_next   = '0;
        addr_next = '0;
        phys_next = '0;
        free_next = '0;
        for (int w = 0; w < N; w++) begin
            if (commit[w] && headEntries[w].arch_rd != '0) begin
                en_next[w]   = 1'b1;
                addr_next[w] = headEntries[w].arch_rd;
                phys_next[w] = headEntries[w].phys_rd;
                if (headEntries[w].prev_phys_rd != '0 &&
                    int'(headEntries[w].prev_phys_rd) < PHYS_REGS) begin
                    free_next[headEntries[w].prev_phys_rd] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            archWriteEnables  <= '0;
            archWriteAddrs    <= '0;
            archWritePhysRegs <= '0;
            freeMask          <= '0;
            instret           <= '0;
        end else begin
            archWriteEnables  <= en_next;
            archWriteAddrs    <= addr_next;
            archWritePhysRegs <= phys_next;
            freeMask          <= free_next;
            instret           <= instret + 64'(retireCount);
        end
    end

endmodule

// File: tb/tb_retire_commit_unit.sv
// tb/tb_retire_commit_unit.sv - scoreboard bench for retire_commit_unit
module tb_retire_commit_unit;
    import retire_commit_unit_pkg::*;

    logic                         clock;
    logic                         reset;
    rob_entry_t [3:0]             headEntries;
    logic [3:0]                   headValids;
    logic [3:0][ROB_IDX_W-1:0]    headIdxs;
    logic                         sqCommitReady;
    logic [2:0]                   retireCount;
    logic [0:0]                   sqCommitCount;
    logic                         robFlush;
    logic [ROB_IDX_W-1:0]         robFlushIdx;
    logic                         bpRecoverEn;
    logic                         recovering;
    logic [3:0]                   archWriteEnables;
    logic [3:0][REG_IDX_W-1:0]    archWriteAddrs;
    logic [3:0][PHYS_TAG_W-1:0]   archWritePhysRegs;
    logic [63:0]                  freeMask;
    logic                         halted;
    logic [63:0]                  instret;

    retire_commit_unit #(
        .N              (4),
        .PHYS_REGS      (64),
        .RECOVER_CYCLES (2),
        .STORES_PER_CYC (1)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .headEntries       (headEntries),
        .headValids        (headValids),
        .headIdxs          (headIdxs),
        .sqCommitReady     (sqCommitReady),
        .retireCount       (retireCount),
        .sqCommitCount     (sqCommitCount),
        .robFlush          (robFlush),
        .robFlushIdx       (robFlushIdx),
        .bpRecoverEn       (bpRecoverEn),
        .recovering        (recovering),
        .archWriteEnables  (archWriteEnables),
        .archWriteAddrs    (archWriteAddrs),
        .archWritePhysRegs (archWritePhysRegs),
        .freeMask          (freeMask),
        .halted            (halted),
        .instret           (instret)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int                         cyc;
        int                         rc;
        int                         sc;
        logic                       fl;
        logic [4:0]                 fidx;
        logic                       rec;
        logic                       hl;
        logic [3:0]                 en;
        logic [3:0][REG_IDX_W-1:0]  addr;
        logic [3:0][PHYS_TAG_W-1:0] phys;
        logic [63:0]                fm;
        logic [63:0]                ir;
    } exp_t;

    exp_t             sb[$];
    exp_t             mon_e;
    int               total = 0;
    int               bad = 0;
    int               cyc = 0;
    rob_entry_t [3:0] ent;
    rob_entry_t [3:0] pent;
    logic [3:0]       pmask = '0;
    logic [63:0]      m_instret = '0;

    task automatic chk(input string nm, input int c, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d act=%0h exp=%0h", nm, c, act, exp);
        end
    endtask

    function automatic rob_entry_t alu(input int rd, input int prd, input int told);
        rob_entry_t e = '0;
        e.complete     = 1'b1;
        e.arch_rd      = REG_IDX_W'(rd);
        e.phys_rd      = PHYS_TAG_W'(prd);
        e.prev_phys_rd = PHYS_TAG_W'(told);
        return e;
    endfunction

    task automatic step(input logic rst, input logic [3:0] v, input logic sq,
                        input int rc, input int sc, input logic fl, input int fidx,
                        input logic rec, input logic hl, input logic [3:0] mask);
        exp_t e;
        @(posedge clock);
        #1;
        reset         = rst;
        headValids    = v;
        sqCommitReady = sq;
        headEntries   = ent;
        e.cyc  = cyc;
        e.rc   = rc;
        e.sc   = sc;
        e.fl   = fl;
        e.fidx = 5'(fidx);
        e.rec  = rec;
        e.hl   = hl;
        e.en   = '0;
        e.addr = '0;
        e.phys = '0;
        e.fm   = '0;
        for (int i = 0; i < 4; i++) begin
            if (pmask[i] && pent[i].arch_rd != '0) begin
                e.en[i]   = 1'b1;
                e.addr[i] = pent[i].arch_rd;
                e.phys[i] = pent[i].phys_rd;
                if (pent[i].prev_phys_rd != '0) e.fm[pent[i].prev_phys_rd] = 1'b1;
            end
        end
        e.ir = m_instret;
        sb.push_back(e);
        m_instret = rst ? 64'd0 : m_instret + 64'(rc);
        pmask     = rst ? 4'b0 : mask;
        pent      = ent;
        cyc++;
    endtask

    always @(negedge clock) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk("retireCount",   mon_e.cyc, 64'(retireCount),       64'(mon_e.rc));
            chk("sqCommitCount", mon_e.cyc, 64'(sqCommitCount),     64'(mon_e.sc));
            chk("robFlush",      mon_e.cyc, 64'(robFlush),          64'(mon_e.fl));
            chk("bpRecoverEn",   mon_e.cyc, 64'(bpRecoverEn),       64'(mon_e.fl));
            chk("robFlushIdx",   mon_e.cyc, 64'(robFlushIdx),       64'(mon_e.fidx));
            chk("recovering",    mon_e.cyc, 64'(recovering),        64'(mon_e.rec));
            chk("halted",        mon_e.cyc, 64'(halted),            64'(mon_e.hl));
            chk("archWriteEn",   mon_e.cyc, 64'(archWriteEnables),  64'(mon_e.en));
            chk("archWriteAddr", mon_e.cyc, 64'(archWriteAddrs),    64'(mon_e.addr));
            chk("archWritePhys", mon_e.cyc, 64'(archWritePhysRegs), 64'(mon_e.phys));
            chk("freeMask",      mon_e.cyc, freeMask,               mon_e.fm);
            chk("instret",       mon_e.cyc, instret,                mon_e.ir);
        end
    end

    task automatic load_t1();
        ent[3] = alu(1, 10, 40);
        ent[2] = alu(2, 11, 41);
        ent[1] = alu(3, 12, 42);
        ent[0] = alu(4, 13, 43);
    endtask

    task automatic load_t4();
        ent[3] = alu(9, 30, 48);
        ent[2] = alu(1, 31, 49);
        ent[2].is_branch     = 1'b1;
        ent[2].pred_taken    = 1'b1;
        ent[2].branch_taken  = 1'b1;
        ent[2].pred_target   = 32'd100;
        ent[2].branch_target = 32'd200;
        ent[1] = alu(2, 32, 50);
        ent[0] = alu(3, 33, 51);
    endtask

    initial begin
        reset         = 1'b1;
        headEntries   = '0;
        headValids    = '0;
        headIdxs      = {5'd7, 5'd6, 5'd5, 5'd4};
        sqCommitReady = 1'b1;
        ent           = '0;
        pent          = '0;
        repeat (2) @(posedge clock);

        load_t1();
        step(1, 4'hF, 1, 0, 0, 0, 0, 0, 0, 4'h0);
        step(0, 4'hF, 1, 4, 0, 0, 0, 0, 0, 4'hF);

        ent[3] = alu(5, 20, 44);
        ent[2] = alu(6, 21, 45);
        ent[2].complete = 1'b0;
        ent[1] = alu(7, 22, 46);
        ent[0] = alu(8, 23, 47);
        step(0, 4'hF, 1, 1, 0, 0, 0, 0, 0, 4'h8);

        ent[3] = alu(0, 0, 0);
        ent[3].is_store = 1'b1;
        ent[2] = ent[3];
        step(0, 4'hF, 1, 1, 1, 0, 0, 0, 0, 4'h8);
        step(0, 4'hF, 0, 0, 0, 0, 0, 0, 0, 4'h0);

        load_t4();
        step(0, 4'hF, 1, 2, 0, 1, 6, 0, 0, 4'hC);
        step(0, 4'hF, 1, 0, 0, 0, 0, 1, 0, 4'h0);
        step(0, 4'hF, 1, 0, 0, 0, 0, 1, 0, 4'h0);

        ent[3] = alu(10, 34, 52);
        ent[2] = alu(11, 35, 53);
        ent[1] = alu(0, 0, 0);
        ent[1].halt = 1'b1;
        ent[0] = alu(12, 36, 54);
        step(0, 4'hF, 1, 3, 0, 0, 0, 0, 0, 4'hE);
        step(0, 4'hF, 1, 0, 0, 0, 0, 0, 1, 4'h0);
        step(0, 4'hF, 1, 0, 0, 0, 0, 0, 1, 4'h0);
        step(1, 4'hF, 1, 0, 0, 0, 0, 0, 1, 4'h0);

        load_t1();
        step(0, 4'hF, 1, 4, 0, 0, 0, 0, 0, 4'hF);
        load_t4();
        step(0, 4'hF, 1, 2, 0, 1, 6, 0, 0, 4'hC);
        step(1, 4'hF, 1, 0, 0, 0, 0, 1, 0, 4'h0);

        load_t1();
        step(0, 4'hF, 1, 4, 0, 0, 0, 0, 0, 4'hF);
        step(0, 4'h0, 1, 0, 0, 0, 0, 0, 0, 4'h0);
        step(0, 4'hB, 1, 1, 0, 0, 0, 0, 0, 4'h8);
        step(0, 4'h0, 1, 0, 0, 0, 0, 0, 0, 4'h0);

        @(posedge clock);
        @(negedge clock);
        #1;
        chk("scoreboard_drained", cyc, 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog cyc=%0d act=running exp=finished", cyc);
        $fatal(1);
    end

endmodule
